// File: rtl/mixer_pkg.sv
// Shared types and sizing helpers for the voice mixer.
package mixer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_SAT
    } mix_state_e;

    function automatic int unsigned unity_gain(input int unsigned gain_frac);
        return 32'd1 << gain_frac;
    endfunction

    // Wide enough that NUM_CH worst-case products cannot overflow before saturation.
    function automatic int unsigned acc_width(input int unsigned sample_w,
                                              input int unsigned gain_w,
                                              input int unsigned num_ch);
        return sample_w + gain_w + 1 + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/mixer_sat.sv
// Combinational fixed-point rescale (arithmetic shift, floor rounding),
// signed clamp to OUT_W bits and clip flag.
module mixer_sat #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic [IN_W-1:0]  acc_i,
    output logic [OUT_W-1:0] sat_o,
    output logic             clip_o
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] shifted;

    always_comb begin
        shifted = $signed(acc_i) >>> SHIFT;
        sat_o   = shifted[OUT_W-1:0];
        clip_o  = 1'b0;
        if (shifted > MAX_V) begin
            sat_o  = {1'b0, {(OUT_W-1){1'b1}}};
            clip_o = 1'b1;
        end else if (shifted < MIN_V) begin
            sat_o  = {1'b1, {(OUT_W-1){1'b0}}};
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/voice_mixer.sv
// N-channel gain-scaled voice mixer with one time-shared multiplier and output saturation.
// Optional peak-hold of |out_sample| enabled by defining MIXER_PEAK_HOLD_EN.
module voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int SAMPLE_W  = 16,
    parameter int GAIN_W    = 5,
    parameter int GAIN_FRAC = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   in_samples,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         gain_wr,
    input  logic [$clog2(NUM_CH)-1:0]    gain_ch,
    input  logic [GAIN_W-1:0]            gain_val,
    output logic                         out_valid,
    output logic [SAMPLE_W-1:0]          out_sample,
    output logic [NUM_CH*SAMPLE_W-1:0]   ch_samples_q,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun,
    output logic [SAMPLE_W-2:0]          peak_abs,
    input  logic                         peak_clr
);

    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int ACC_W  = int'(acc_width(SAMPLE_W, GAIN_W, NUM_CH));
    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(unity_gain(GAIN_FRAC));
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

    mix_state_e          state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [NUM_CH-1:0]   mask_q;
    logic [GAIN_W-1:0]   gain_q [NUM_CH];

    logic signed [SAMPLE_W-1:0] cur_s;
    logic signed [PROD_W-1:0]   s_ext, g_ext, prod;
    logic [SAMPLE_W-1:0]        sat_val;
    logic                       sat_clip;
    logic                       last_step;

    always_comb begin
        cur_s     = ch_samples_q[idx_q*SAMPLE_W +: SAMPLE_W];
        s_ext     = PROD_W'(cur_s);
        g_ext     = PROD_W'({1'b0, gain_q[idx_q]});
        prod      = s_ext * g_ext;
        acc_d     = acc_q;
        if (mask_q[idx_q])
            acc_d = acc_q + ACC_W'(prod);
        last_step = (state_q == ST_ACC) && (idx_q == LAST_IDX);
    end

    mixer_sat #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_W),
        .SHIFT (GAIN_FRAC)
    ) u_sat (
        .acc_i  (acc_d),
        .sat_o  (sat_val),
        .clip_o (sat_clip)
    );

    // The final ACC step saturates acc_d directly so out_valid lands in the SAT
    // cycle; SAT therefore already accepts a new in_valid like IDLE does.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            mask_q       <= '0;
            ch_samples_q <= '0;
            out_sample   <= '0;
            out_valid    <= 1'b0;
            clip         <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++)
                gain_q[c] <= UNITY;
        end else begin
            out_valid <= 1'b0;
            for (int unsigned c = 0; c < NUM_CH; c++)
                if (gain_wr && gain_ch == IDX_W'(c))
                    gain_q[c] <= gain_val;

            case (state_q)
                ST_IDLE, ST_SAT: begin
                    if (in_valid) begin
                        ch_samples_q <= in_samples;
                        mask_q       <= ch_enable;
                        acc_q        <= '0;
                        idx_q        <= '0;
                        busy         <= 1'b1;
                        state_q      <= ST_ACC;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (in_valid)
                        overrun <= 1'b1;
                    acc_q <= acc_d;
                    if (last_step) begin
                        out_sample <= sat_val;
                        clip       <= sat_clip;
                        out_valid  <= 1'b1;
                        busy       <= 1'b0;
                        state_q    <= ST_SAT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MIXER_PEAK_HOLD_EN
    localparam logic [SAMPLE_W-1:0] SMIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [SAMPLE_W-2:0] sat_abs;
    logic [SAMPLE_W-2:0] peak_q;
    logic [SAMPLE_W-1:0] neg_val;

    always_comb begin
        neg_val = -sat_val;
        if (!sat_val[SAMPLE_W-1])
            sat_abs = sat_val[SAMPLE_W-2:0];
        else if (sat_val == SMIN)
            sat_abs = '1;
        else
            sat_abs = neg_val[SAMPLE_W-2:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            peak_q <= '0;
        else if (peak_clr)
            peak_q <= '0;
        else if (last_step && sat_abs > peak_q)
            peak_q <= sat_abs;
    end

    assign peak_abs = peak_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_abs        = '0;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: fixed vectors, multi-cycle corner sequences
// and randomized mixes against an arithmetic reference model.
module tb_voice_mixer;

`ifdef MIXER_PEAK_HOLD_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic [63:0]        in_samples;
    logic [3:0]         ch_enable;
    logic               gain_wr;
    logic [1:0]         gain_ch;
    logic [4:0]         gain_val;
    logic               out_valid;
    logic signed [15:0] out_sample;
    logic [63:0]        ch_samples_q;
    logic               busy, clip, overrun;
    logic [14:0]        peak_abs;
    logic               peak_clr;

    // three-channel instance: gain_ch can address a channel that does not exist
    logic               in_valid3, gain_wr3, out_valid3, busy3, clip3, overrun3;
    logic [47:0]        in_samples3, ch_samples_q3;
    logic [2:0]         ch_enable3;
    logic [1:0]         gain_ch3;
    logic [4:0]         gain_val3;
    logic signed [15:0] out_sample3;
    logic [14:0]        peak_abs3;

    always #5 clk = ~clk;

    voice_mixer #(.NUM_CH(4), .SAMPLE_W(16), .GAIN_W(5), .GAIN_FRAC(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_samples(in_samples),
        .ch_enable(ch_enable), .gain_wr(gain_wr), .gain_ch(gain_ch), .gain_val(gain_val),
        .out_valid(out_valid), .out_sample(out_sample), .ch_samples_q(ch_samples_q),
        .busy(busy), .clip(clip), .overrun(overrun), .peak_abs(peak_abs), .peak_clr(peak_clr)
    );

    voice_mixer #(.NUM_CH(3), .SAMPLE_W(16), .GAIN_W(5), .GAIN_FRAC(4)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid3), .in_samples(in_samples3),
        .ch_enable(ch_enable3), .gain_wr(gain_wr3), .gain_ch(gain_ch3), .gain_val(gain_val3),
        .out_valid(out_valid3), .out_sample(out_sample3), .ch_samples_q(ch_samples_q3),
        .busy(busy3), .clip(clip3), .overrun(overrun3), .peak_abs(peak_abs3), .peak_clr(1'b0)
    );

    int checks = 0;
    int errors = 0;
    int gm[4];
    int peak_m;

    typedef struct {
        int         s[4];
        logic [3:0] en;
        int         g[4];
        int         es;
        bit         ec;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                                input logic [3:0] en, input int g0, input int g1,
                                input int g2, input int g3, input int es, input bit ec);
        vec_t v;
        v.s = '{s0, s1, s2, s3};
        v.en = en;
        v.g = '{g0, g1, g2, g3};
        v.es = es;
        v.ec = ec;
        return v;
    endfunction

    function automatic logic [63:0] pack4(input int s0, input int s1, input int s2, input int s3);
        logic [63:0] p;
        p[15:0]  = 16'(s0);
        p[31:16] = 16'(s1);
        p[47:32] = 16'(s2);
        p[63:48] = 16'(s3);
        return p;
    endfunction

    // Reference: exact integer sum, floor division by 2^GAIN_FRAC, clamp to 16-bit range.
    function automatic void model(input logic [63:0] smp, input logic [3:0] en,
                                  output int exp_s, output bit exp_c);
        longint sum = 0;
        longint q;
        for (int c = 0; c < 4; c++)
            if (en[c])
                sum += longint'($signed(smp[c*16 +: 16])) * gm[c];
        q = sum / 16;
        if (sum < 0 && (sum % 16) != 0)
            q = q - 1;
        exp_c = 1'b0;
        if (q > 32767) begin q = 32767; exp_c = 1'b1; end
        if (q < -32768) begin q = -32768; exp_c = 1'b1; end
        exp_s = int'(q);
    endfunction

    function automatic void peak_update(input int v);
        int a;
        a = (v < 0) ? -v : v;
        if (a > 32767) a = 32767;
        if (PEAK_EN && a > peak_m) peak_m = a;
    endfunction

    task automatic set_gain(input int ch, input int val);
        gain_wr = 1'b1;
        gain_ch = 2'(ch);
        gain_val = 5'(val);
        tick();
        gain_wr = 1'b0;
        gm[ch] = val;
    endtask

    task automatic all_unity();
        for (int c = 0; c < 4; c++)
            if (gm[c] != 16) set_gain(c, 16);
    endtask

    task automatic start(input logic [63:0] smp, input logic [3:0] en);
        in_samples = smp;
        ch_enable = en;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // lat counts cycles after the in_valid cycle; -1 if out_valid never came
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic run_mix(input string name, input logic [63:0] smp, input logic [3:0] en);
        int lat, es;
        bit ec;
        model(smp, en, es, ec);
        start(smp, en);
        wait_out(lat);
        check({name, " latency"}, lat, 5);
        check({name, " sample"}, out_sample, es);
        check({name, " clip"}, clip, ec);
        peak_update(es);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, es, pulses;
        bit ec;
        logic [63:0] smp_a;
        logic signed [15:0] first_out;

        reset_n = 1'b0; in_valid = 1'b0; in_samples = '0; ch_enable = '0;
        gain_wr = 1'b0; gain_ch = '0; gain_val = '0; peak_clr = 1'b0;
        in_valid3 = 1'b0; in_samples3 = '0; ch_enable3 = '0;
        gain_wr3 = 1'b0; gain_ch3 = '0; gain_val3 = '0;
        for (int c = 0; c < 4; c++) gm[c] = 16;
        peak_m = 0;

        tbl[0] = mk(100, 200, 300, 400, 4'hF, 16, 16, 16, 16, 1000, 1'b0);
        tbl[1] = mk(32767, 0, 0, 0, 4'hF, 31, 0, 0, 0, 32767, 1'b1);
        tbl[2] = mk(-32768, 0, 0, 0, 4'hF, 31, 0, 0, 0, -32768, 1'b1);
        tbl[3] = mk(1000, -1000, 500, 7, 4'b0101, 16, 16, 16, 16, 1500, 1'b0);
        tbl[4] = mk(1000, -1000, 500, 7, 4'b0000, 16, 16, 16, 16, 0, 1'b0);
        tbl[5] = mk(-1, 0, 0, 0, 4'hF, 1, 0, 0, 0, -1, 1'b0);
        tbl[6] = mk(7, 0, 0, 0, 4'hF, 1, 0, 0, 0, 0, 1'b0);
        tbl[7] = mk(-32768, -32768, -32768, -32768, 4'hF, 16, 16, 16, 16, -32768, 1'b1);
        tbl[8] = mk(16384, 16384, 0, 0, 4'hF, 16, 16, 16, 16, 32767, 1'b1);
        tbl[9] = mk(32767, 5, 5, 5, 4'b0001, 16, 16, 16, 16, 32767, 1'b0);

        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset out_valid", out_valid, 0);
        check("reset out_sample", out_sample, 0);
        check("reset clip", clip, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        check("reset peak_abs", peak_abs, 0);
        check("reset ch_samples_q", ch_samples_q, 0);

        // fixed vectors (entry 0 relies on reset gains being unity)
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 4; c++)
                if (gm[c] != tbl[i].g[c]) set_gain(c, tbl[i].g[c]);
            smp_a = pack4(tbl[i].s[0], tbl[i].s[1], tbl[i].s[2], tbl[i].s[3]);
            start(smp_a, tbl[i].en);
            if (i == 0) check("busy after accept", busy, 1);
            wait_out(lat);
            check($sformatf("vec%0d latency", i), lat, 5);
            check($sformatf("vec%0d sample", i), out_sample, tbl[i].es);
            check($sformatf("vec%0d clip", i), clip, tbl[i].ec);
            check($sformatf("vec%0d busy", i), busy, 0);
            check($sformatf("vec%0d captured", i), ch_samples_q, smp_a);
            tick();
            check($sformatf("vec%0d out_valid single", i), out_valid, 0);
            check($sformatf("vec%0d sample held", i), out_sample, tbl[i].es);
        end

        // gain written to the channel being read in that same cycle: old gain applies
        all_unity();
        start(pack4(100, 0, 0, 0), 4'hF);
        gain_wr = 1'b1; gain_ch = 2'd0; gain_val = 5'd0;
        tick();
        gain_wr = 1'b0;
        gm[0] = 0;
        wait_out(lat);
        check("same-cycle gain old value", out_sample, 100);
        run_mix("new gain visible", pack4(100, 0, 0, 0), 4'hF);
        all_unity();

        // in_valid while busy is dropped and flags overrun
        smp_a = pack4(10, 20, 30, 40);
        model(smp_a, 4'hF, es, ec);
        start(smp_a, 4'hF);
        tick();
        start(pack4(1000, 1000, 1000, 1000), 4'hF);
        pulses = 0;
        first_out = '0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) begin pulses++; first_out = out_sample; end
            tick();
        end
        check("overrun single out_valid", pulses, 1);
        check("overrun kept first", first_out, es);
        check("overrun flag", overrun, 1);
        check("overrun captured first", ch_samples_q, smp_a);

        // back-to-back: in_valid in the out_valid cycle is accepted
        start(smp_a, 4'hF);
        wait_out(lat);
        check("b2b first sample", out_sample, es);
        smp_a = pack4(-7, 3000, -2000, 12);
        model(smp_a, 4'hF, es, ec);
        start(smp_a, 4'hF);
        wait_out(lat);
        check("b2b second latency", lat, 5);
        check("b2b second sample", out_sample, es);
        check("overrun sticky", overrun, 1);

        // peak hold
        peak_clr = 1'b1; tick(); peak_clr = 1'b0;
        peak_m = 0;
        run_mix("peak -300", pack4(-300, 0, 0, 0), 4'b0001);
        run_mix("peak 120", pack4(120, 0, 0, 0), 4'b0001);
        tick();
        check("peak after -300,120", peak_abs, PEAK_EN ? 300 : 0);
        start(pack4(50, 0, 0, 0), 4'b0001);
        wait_out(lat);
        check("peak clr mix sample", out_sample, 50);
        peak_clr = 1'b1; tick(); peak_clr = 1'b0;
        check("peak cleared", peak_abs, 0);
        peak_m = 0;

        // randomized mixes against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                set_gain($urandom_range(0, 3), $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0)
                smp_a = {$urandom(), $urandom()};
            else
                smp_a = pack4($urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000,
                              $urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000);
            run_mix($sformatf("rand%0d", i), smp_a, 4'($urandom_range(0, 15)));
            tick();
            check($sformatf("rand%0d peak", i), peak_abs, peak_m);
        end

        // reset during accumulation aborts the mix and restores unity gains
        set_gain(1, 3);
        start(pack4(0, 100, 0, 0), 4'hF);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) gm[c] = 16;
        peak_m = 0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("abort no out_valid", pulses, 0);
        check("abort out_sample", out_sample, 0);
        check("abort overrun", overrun, 0);
        check("abort busy", busy, 0);
        check("abort captured", ch_samples_q, 0);
        check("abort peak", peak_abs, 0);
        run_mix("gain unity after reset", pack4(0, 100, 0, 0), 4'hF);

        // gain write to a non-existent channel is ignored
        gain_wr3 = 1'b1; gain_ch3 = 2'd3; gain_val3 = 5'd0;
        tick();
        gain_wr3 = 1'b0;
        in_samples3 = {16'sd30, 16'sd20, 16'sd10};
        ch_enable3 = 3'b111;
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        lat = 1;
        while (!out_valid3 && lat < 20) begin tick(); lat++; end
        if (!out_valid3) lat = -1;
        check("3ch latency", lat, 4);
        check("3ch out-of-range gain ignored", out_sample3, 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
